// File: rtl/pico_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pico_bus_arbiter_pkg
// Shared types for the two-master PicoBus arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, OWN0, OWN1, TURN)
//   MST0 / MST1  : master index constants, also used as read tags
//   pico_strb_t  : registered slave strobe bundle (rd, wr)
//   f_own_state  : maps a master index to its ownership state
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package pico_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2,
      ST_TURN = 2'd3
   } arb_state_e;

   localparam logic MST0 = 1'b0;
   localparam logic MST1 = 1'b1;

   typedef struct packed {
      logic rd;
      logic wr;
   } pico_strb_t;

   function automatic arb_state_e f_own_state(input logic idx);
      return (idx == MST1) ? ST_OWN1 : ST_OWN0;
   endfunction

endpackage

// File: rtl/pico_bus_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// pico_bus_rd_tag_pipe
// Tracks which master issued each slave read and steers the fixed-latency
// read data back to it. A read accepted in cycle t is tagged, travels LAT
// stages, and the slave data present in cycle t+LAT is registered into the
// tagged master's rdata with a one-cycle rvalid pulse in t+LAT+1. The other
// master's rdata keeps its previous value.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_vld, i_tag          read accepted this cycle, issuing master index
//   i_data [W]            slave read data (PicoDataOut)
//   o_rdata0/o_rvalid0    master 0 read return
//   o_rdata1/o_rvalid1    master 1 read return
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pico_bus_rd_tag_pipe
   import pico_bus_arbiter_pkg::*;
#(
   parameter int W   = 128,
   parameter int LAT = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_vld,
   input  logic         i_tag,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_rdata0,
   output logic         o_rvalid0,
   output logic [W-1:0] o_rdata1,
   output logic         o_rvalid1
);

   logic [LAT-1:0] r_vld_p;
   logic [LAT-1:0] r_tag_p;
   logic [W-1:0]   r_rdata0;
   logic [W-1:0]   r_rdata1;
   logic           r_rvalid0;
   logic           r_rvalid1;
   logic           w_ret0;
   logic           w_ret1;

   assign w_ret0 = r_vld_p[LAT-1] && (r_tag_p[LAT-1] == MST0);
   assign w_ret1 = r_vld_p[LAT-1] && (r_tag_p[LAT-1] == MST1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld_p   <= '0;
         r_tag_p   <= '0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_vld_p   <= {r_vld_p[LAT-2:0], i_vld};
         r_tag_p   <= {r_tag_p[LAT-2:0], i_tag};
         r_rvalid0 <= w_ret0;
         r_rvalid1 <= w_ret1;
         if (w_ret0) r_rdata0 <= i_data;
         if (w_ret1) r_rdata1 <= i_data;
      end
   end

   assign o_rdata0  = r_rdata0;
   assign o_rvalid0 = r_rvalid0;
   assign o_rdata1  = r_rdata1;
   assign o_rvalid1 = r_rvalid1;

endmodule

// File: rtl/pico_bus_arbiter.sv
// -----------------------------------------------------------------------------
// pico_bus_arbiter
// Shares one PicoBus slave segment between the host stream bridge (master 0)
// and an on-chip engine (master 1). One owner at a time, round-robin between
// transactions, one TURN cycle on every release, all slave-bound signals
// registered, read data routed back to the issuing master (3-cycle latency).
//
// Optional feature: define PICOBUS_ARB_HOLD_LIMIT_EN to preempt an owner after
// MAX_HOLD cycles while the other master waits. Undefined: MAX_HOLD has no
// effect and an owner keeps the bus until it drops req.
//
// Ports:
//   PicoClk, PicoRst               clock, synchronous active-high reset
//   mK_req/mK_gnt                  request / grant (K = 0,1)
//   mK_addr/mK_rd/mK_wr/mK_wdata   master command
//   mK_rdata/mK_rvalid             master read return
//   PicoAddr/PicoRd/PicoWr/PicoDataIn  registered slave command
//   PicoDataOut                    slave read data, valid one cycle after PicoRd
//   err                            sticky protocol-error flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pico_bus_arbiter
   import pico_bus_arbiter_pkg::*;
#(
   parameter int W        = 128,
   parameter int MAX_HOLD = 64
) (
   input  logic         PicoClk,
   input  logic         PicoRst,
   input  logic         m0_req,
   output logic         m0_gnt,
   input  logic [31:0]  m0_addr,
   input  logic         m0_rd,
   input  logic         m0_wr,
   input  logic [W-1:0] m0_wdata,
   output logic [W-1:0] m0_rdata,
   output logic         m0_rvalid,
   input  logic         m1_req,
   output logic         m1_gnt,
   input  logic [31:0]  m1_addr,
   input  logic         m1_rd,
   input  logic         m1_wr,
   input  logic [W-1:0] m1_wdata,
   output logic [W-1:0] m1_rdata,
   output logic         m1_rvalid,
   output logic [31:0]  PicoAddr,
   output logic         PicoRd,
   output logic         PicoWr,
   output logic [W-1:0] PicoDataIn,
   input  logic [W-1:0] PicoDataOut,
   output logic         err
);

   arb_state_e   r_state;
   arb_state_e   w_state_nxt;
   logic         r_last;
   logic         w_last_nxt;
   logic         w_gnt0;
   logic         w_gnt1;
   logic         w_hold_fire;
   pico_strb_t   r_strb;
   pico_strb_t   w_strb;
   logic [31:0]  r_addr;
   logic [W-1:0] r_wdata;
   logic         r_err;
   logic         w_err_evt;
   logic         w_tag;
   logic [31:0]  w_addr;
   logic [W-1:0] w_wdata;

   // Grants decode straight from the state register, so a grant drops in the
   // very cycle the FSM enters TURN.
   assign w_gnt0 = (r_state == ST_OWN0);
   assign w_gnt1 = (r_state == ST_OWN1);

`ifdef PICOBUS_ARB_HOLD_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   logic [CNT_W-1:0] r_hold_cnt;
   logic             w_other_req;

   assign w_other_req = (w_gnt0 && m1_req) || (w_gnt1 && m0_req);
   assign w_hold_fire = w_other_req && (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

   always_ff @(posedge PicoClk) begin
      if (PicoRst || (w_state_nxt != r_state)) r_hold_cnt <= '0;
      else if (w_other_req)                     r_hold_cnt <= r_hold_cnt + CNT_W'(1);
   end
`else
   // No preemption in this build; the compare is constant false.
   assign w_hold_fire = (MAX_HOLD < 0);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         ST_IDLE: begin
            // Contention goes to the master that was not granted last.
            if (m0_req && m1_req) w_state_nxt = f_own_state(~r_last);
            else if (m0_req)      w_state_nxt = ST_OWN0;
            else if (m1_req)      w_state_nxt = ST_OWN1;
         end
         ST_OWN0: begin
            if (!m0_req || w_hold_fire) begin
               w_state_nxt = ST_TURN;
               w_last_nxt  = MST0;
            end
         end
         ST_OWN1: begin
            if (!m1_req || w_hold_fire) begin
               w_state_nxt = ST_TURN;
               w_last_nxt  = MST1;
            end
         end
         ST_TURN: begin
            if ((r_last == MST0) ? m1_req : m0_req)      w_state_nxt = f_own_state(~r_last);
            else if ((r_last == MST0) ? m0_req : m1_req) w_state_nxt = f_own_state(r_last);
            else                                         w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Command acceptance: only the owner's strobes reach the bus. rd+wr together
   // forwards the write and drops the read; any strobe without grant is dropped.
   always_comb begin
      w_strb    = '0;
      w_addr    = m0_addr;
      w_wdata   = m0_wdata;
      w_tag     = MST0;
      w_err_evt = 1'b0;
      if (w_gnt1) begin
         w_addr  = m1_addr;
         w_wdata = m1_wdata;
         w_tag   = MST1;
      end
      if (w_gnt0) begin
         w_strb.wr = m0_wr;
         w_strb.rd = m0_rd && !m0_wr;
      end else if (w_gnt1) begin
         w_strb.wr = m1_wr;
         w_strb.rd = m1_rd && !m1_wr;
      end
      if ((!w_gnt0 && (m0_rd || m0_wr)) || (w_gnt0 && m0_rd && m0_wr)) w_err_evt = 1'b1;
      if ((!w_gnt1 && (m1_rd || m1_wr)) || (w_gnt1 && m1_rd && m1_wr)) w_err_evt = 1'b1;
   end

   always_ff @(posedge PicoClk) begin
      if (PicoRst) begin
         r_state <= ST_IDLE;
         r_last  <= MST1;
         r_strb  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_strb  <= w_strb;
         if (w_strb.rd || w_strb.wr) r_addr  <= w_addr;
         if (w_strb.wr)              r_wdata <= w_wdata;
         if (w_err_evt)              r_err   <= 1'b1;
      end
   end

   pico_bus_rd_tag_pipe #(
      .W   (W),
      .LAT (2)
   ) u_rd_tag_pipe (
      .i_clk     (PicoClk),
      .i_rst     (PicoRst),
      .i_vld     (w_strb.rd),
      .i_tag     (w_tag),
      .i_data    (PicoDataOut),
      .o_rdata0  (m0_rdata),
      .o_rvalid0 (m0_rvalid),
      .o_rdata1  (m1_rdata),
      .o_rvalid1 (m1_rvalid)
   );

   assign m0_gnt     = w_gnt0;
   assign m1_gnt     = w_gnt1;
   assign PicoAddr   = r_addr;
   assign PicoRd     = r_strb.rd;
   assign PicoWr     = r_strb.wr;
   assign PicoDataIn = r_wdata;
   assign err        = r_err;

endmodule

// File: tb/tb_pico_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pico_bus_arbiter
// Directed bench: a per-cycle vector table for grant/write/error behaviour,
// plus hand-written sequences for read latency, read across handover, the
// hold limit (PICOBUS_ARB_HOLD_LIMIT_EN) and reset during an in-flight read.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pico_bus_arbiter;

   localparam int W  = 128;
   localparam int MH = 4;

   logic         PicoClk = 1'b0;
   logic         PicoRst;
   logic         m0_req, m0_rd, m0_wr, m1_req, m1_rd, m1_wr;
   logic         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0]  m0_addr, m1_addr, PicoAddr;
   logic [W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic [W-1:0] PicoDataIn, PicoDataOut;
   logic         PicoRd, PicoWr, err;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 PicoClk = ~PicoClk;

   pico_bus_arbiter #(.W(W), .MAX_HOLD(MH)) dut (
      .PicoClk(PicoClk), .PicoRst(PicoRst),
      .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_addr(m0_addr), .m0_rd(m0_rd),
      .m0_wr(m0_wr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
      .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_addr(m1_addr), .m1_rd(m1_rd),
      .m1_wr(m1_wr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
      .PicoAddr(PicoAddr), .PicoRd(PicoRd), .PicoWr(PicoWr),
      .PicoDataIn(PicoDataIn), .PicoDataOut(PicoDataOut), .err(err)
   );

   // Slave read data model: data appears the cycle after PicoRd.
   function automatic logic [W-1:0] f_slv(input logic [31:0] a);
      if (a == 32'h200) return {{(W-32){1'b0}}, 32'h0000_DEAD};
      return {{(W-32){1'b0}}, a ^ 32'h5A5A_0000};
   endfunction

   always @(posedge PicoClk) PicoDataOut <= PicoRd ? f_slv(PicoAddr) : '0;

   typedef struct {
      logic        rst, q0, w0, rd0;
      logic [31:0] a0, d0;
      logic        q1, w1, rd1;
      logic        g0, g1, pwr, prd;
      logic [31:0] pa, pd;
      logic        e;
   } vec_t;

   function automatic vec_t mk(input logic rst, q0, w0, rd0, input logic [31:0] a0, d0,
                               input logic q1, w1, rd1, input logic g0, g1, pwr, prd,
                               input logic [31:0] pa, pd, input logic e);
      vec_t v;
      v.rst = rst; v.q0 = q0; v.w0 = w0; v.rd0 = rd0; v.a0 = a0; v.d0 = d0;
      v.q1 = q1; v.w1 = w1; v.rd1 = rd1;
      v.g0 = g0; v.g1 = g1; v.pwr = pwr; v.prd = prd; v.pa = pa; v.pd = pd; v.e = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge PicoClk);
      #1;
   endtask

   task automatic clr_inputs();
      m0_req = 0; m0_rd = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_rd = 0; m1_wr = 0; m1_addr = 32'h300;
      m1_wdata = {{(W-32){1'b0}}, 32'h5555_5555};
   endtask

   task automatic do_reset();
      clr_inputs();
      PicoRst = 1;
      step();
      step();
      PicoRst = 0;
   endtask

   vec_t           tbl[24];
   logic [191:0]   act, exp;
   logic [7:0]     g0b, g1b, rv0b, rv1b, prdb;
   logic [W-1:0]   cap0, cap1, hold0;
   localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002,
                           C = 32'hCCCC_0003, D = 32'hDDDD_0004;

   initial begin
      //          rst q0 w0 rd0 a0       d0  q1 w1 rd1 | g0 g1 pwr prd pa       pd e
      tbl[0]  = mk(0, 1, 0, 0, 32'h0,   0,  0, 0, 0,    0, 0, 0, 0, 32'h0,   0, 0);
      tbl[1]  = mk(0, 1, 1, 0, 32'h100, A,  0, 0, 0,    1, 0, 0, 0, 32'h0,   0, 0);
      tbl[2]  = mk(0, 1, 1, 0, 32'h110, B,  0, 0, 0,    1, 0, 1, 0, 32'h100, A, 0);
      tbl[3]  = mk(0, 1, 0, 0, 32'h0,   0,  0, 0, 0,    1, 0, 1, 0, 32'h110, B, 0);
      tbl[4]  = mk(0, 0, 0, 0, 32'h0,   0,  0, 0, 0,    1, 0, 0, 0, 32'h110, B, 0);
      tbl[5]  = mk(0, 0, 0, 0, 32'h0,   0,  0, 0, 0,    0, 0, 0, 0, 32'h110, B, 0);
      tbl[6]  = mk(1, 0, 0, 0, 32'h0,   0,  0, 0, 0,    0, 0, 0, 0, 32'h110, B, 0);
      tbl[7]  = mk(0, 1, 0, 0, 32'h0,   0,  1, 0, 0,    0, 0, 0, 0, 32'h0,   0, 0);
      tbl[8]  = mk(0, 1, 0, 0, 32'h0,   0,  1, 0, 0,    1, 0, 0, 0, 32'h0,   0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 32'h0,   0,  1, 0, 0,    1, 0, 0, 0, 32'h0,   0, 0);
      tbl[10] = mk(0, 0, 0, 0, 32'h0,   0,  1, 0, 0,    0, 0, 0, 0, 32'h0,   0, 0);
      tbl[11] = mk(0, 0, 0, 0, 32'h0,   0,  1, 0, 0,    0, 1, 0, 0, 32'h0,   0, 0);
      tbl[12] = mk(0, 1, 0, 0, 32'h0,   0,  0, 0, 0,    0, 1, 0, 0, 32'h0,   0, 0);
      tbl[13] = mk(0, 1, 0, 0, 32'h0,   0,  1, 0, 0,    0, 0, 0, 0, 32'h0,   0, 0);
      tbl[14] = mk(0, 1, 0, 0, 32'h0,   0,  0, 0, 0,    1, 0, 0, 0, 32'h0,   0, 0);
      tbl[15] = mk(0, 1, 1, 1, 32'h400, C,  0, 0, 0,    1, 0, 0, 0, 32'h0,   0, 0);
      tbl[16] = mk(0, 1, 0, 0, 32'h0,   0,  0, 0, 0,    1, 0, 1, 0, 32'h400, C, 1);
      tbl[17] = mk(0, 1, 0, 0, 32'h0,   0,  0, 0, 0,    1, 0, 0, 0, 32'h400, C, 1);
      tbl[18] = mk(1, 0, 0, 0, 32'h0,   0,  0, 0, 0,    1, 0, 0, 0, 32'h400, C, 1);
      tbl[19] = mk(0, 1, 0, 0, 32'h0,   0,  0, 0, 0,    0, 0, 0, 0, 32'h0,   0, 0);
      tbl[20] = mk(0, 1, 0, 0, 32'h0,   0,  0, 1, 0,    1, 0, 0, 0, 32'h0,   0, 0);
      tbl[21] = mk(0, 0, 0, 0, 32'h0,   0,  0, 0, 0,    1, 0, 0, 0, 32'h0,   0, 1);
      tbl[22] = mk(0, 0, 1, 0, 32'h500, D,  0, 0, 0,    0, 0, 0, 0, 32'h0,   0, 1);
      tbl[23] = mk(0, 0, 0, 0, 32'h0,   0,  0, 0, 0,    0, 0, 0, 0, 32'h0,   0, 1);

      // Reset state
      do_reset();
      @(negedge PicoClk);
      chk("reset_ctrl", {m0_gnt, m1_gnt, PicoRd, PicoWr, m0_rvalid, m1_rvalid, err}, '0);
      chk("reset_addr", PicoAddr, '0);
      chk("reset_wdata", PicoDataIn, '0);
      chk("reset_rdata", m0_rdata | m1_rdata, '0);
      step();

      // Vector table: inputs for each cycle, outputs observed in that cycle
      for (int i = 0; i < 24; i++) begin
         PicoRst = tbl[i].rst;
         m0_req = tbl[i].q0; m0_wr = tbl[i].w0; m0_rd = tbl[i].rd0;
         m0_addr = tbl[i].a0; m0_wdata = {{(W-32){1'b0}}, tbl[i].d0};
         m1_req = tbl[i].q1; m1_wr = tbl[i].w1; m1_rd = tbl[i].rd1;
         @(negedge PicoClk);
         act = {m0_gnt, m1_gnt, PicoWr, PicoRd, err, PicoAddr, PicoDataIn};
         exp = {tbl[i].g0, tbl[i].g1, tbl[i].pwr, tbl[i].prd, tbl[i].e, tbl[i].pa,
                {(W-32){1'b0}}, tbl[i].pd};
         chk($sformatf("vec%0d", i), act, exp);
         step();
      end
      PicoRst = 0;

      // Read latency: m0 rd 0x200 -> rvalid exactly 3 cycles later
      do_reset();
      m0_req = 1;
      step();
      m0_rd = 1; m0_addr = 32'h200;
      rv0b = '0; rv1b = '0; prdb = '0; g1b = '0; cap0 = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge PicoClk);
         rv0b[k] = m0_rvalid; rv1b[k] = m1_rvalid; prdb[k] = PicoRd; g1b[k] = m1_gnt;
         if (k == 3) cap0 = m0_rdata;
         step();
         m0_rd = 0;
      end
      chk("rd_rvalid0", rv0b, 8'b0000_1000);
      chk("rd_picord", prdb, 8'b0000_0010);
      chk("rd_rvalid1", rv1b | g1b, '0);
      chk("rd_rdata0", cap0, f_slv(32'h200));

      // Read in last owned cycle, then handover to m1
      do_reset();
      m0_req = 1; m1_req = 1;
      step();
      g0b = '0; g1b = '0; rv0b = '0; rv1b = '0; cap0 = '0; cap1 = '0; hold0 = '0;
      for (int k = 0; k < 7; k++) begin
         case (k)
            0: begin m0_rd = 1; m0_addr = 32'h210; m0_req = 0; end
            1: m0_rd = 0;
            2: begin m1_rd = 1; m1_addr = 32'h330; end
            3: m1_rd = 0;
            default: ;
         endcase
         @(negedge PicoClk);
         g0b[k] = m0_gnt; g1b[k] = m1_gnt; rv0b[k] = m0_rvalid; rv1b[k] = m1_rvalid;
         if (k == 3) cap0 = m0_rdata;
         if (k == 5) cap1 = m1_rdata;
         if (k == 6) hold0 = m0_rdata;
         step();
      end
      chk("ho_gnt0", g0b, 8'b0000_0001);
      chk("ho_gnt1", g1b, 8'b0111_1100);
      chk("ho_rvalid0", rv0b, 8'b0000_1000);
      chk("ho_rvalid1", rv1b, 8'b0010_0000);
      chk("ho_rdata0", cap0, f_slv(32'h210));
      chk("ho_rdata1", cap1, f_slv(32'h330));
      chk("ho_rdata0_hold", hold0, f_slv(32'h210));

      // Hold limit with both masters requesting continuously
      do_reset();
      m0_req = 1; m1_req = 1;
      g0b = '0; g1b = '0;
      for (int k = 0; k < 8; k++) begin
         step();
         @(negedge PicoClk);
         g0b[k] = m0_gnt; g1b[k] = m1_gnt;
      end
      step();
`ifdef PICOBUS_ARB_HOLD_LIMIT_EN
      chk("hold_gnt0", g0b, 8'b0000_1111);
      chk("hold_gnt1", g1b, 8'b1110_0000);
`else
      chk("hold_gnt0", g0b, 8'b1111_1111);
      chk("hold_gnt1", g1b, 8'b0000_0000);
`endif

      // Reset one cycle after PicoRd: the read never returns
      do_reset();
      m0_req = 1;
      step();
      m0_rd = 1; m0_addr = 32'h220;
      step();
      m0_rd = 0;
      @(negedge PicoClk);
      chk("rst_rd_picord", PicoRd, 1'b1);
      step();
      PicoRst = 1; m0_req = 0;
      step();
      @(negedge PicoClk);
      chk("rst_rd_ctrl", {m0_gnt, m1_gnt, PicoRd, PicoWr, m0_rvalid, m1_rvalid, err}, '0);
      chk("rst_rd_data", {PicoAddr, PicoDataIn[31:0], m0_rdata[31:0]}, '0);
      rv0b = '0;
      rv0b[0] = m0_rvalid;
      step();
      PicoRst = 0;
      for (int k = 1; k < 4; k++) begin
         @(negedge PicoClk);
         rv0b[k] = m0_rvalid | m1_rvalid;
         step();
      end
      chk("rst_rd_norvalid", rv0b, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
